// File: rtl/seq_gen_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_ctrl_pkg
// Purpose  : Shared types and constants for the run-length sequence
//            generator: FSM state encoding and the default counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_gen_ctrl_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ONES  = 2'd1,
        ST_ZERO  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_gen_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_ctrl_if
// Purpose  : Valid/ready symbol stream between the sequence generator and
//            the downstream serializer.
// Signals  : seq      - current symbol (master -> slave)
//            seq_vld  - symbol valid   (master -> slave)
//            seq_rdy  - consumer ready (slave -> master)
//            A transfer happens on a cycle with seq_vld & seq_rdy.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_gen_ctrl_if;

    logic seq;
    logic seq_vld;
    logic seq_rdy;

    modport master (output seq, output seq_vld, input  seq_rdy);
    modport slave  (input  seq, input  seq_vld, output seq_rdy);

endinterface
`default_nettype wire

// File: rtl/seq_run_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_run_cnt
// Purpose  : Run-length bookkeeping for seq_gen_ctrl. Holds the latched
//            configuration (max_run, wrap), the current run length k and the
//            position pos inside the run of ones, and decodes the flags the
//            FSM branches on.
// Ports    : i_clk, i_resetn       - clock, async active-low reset
//            load                  - accepted start: latch cfg, clear k/pos
//            pos_inc               - one '1' symbol transferred
//            run_next              - advance to the next run (k++, pos=0)
//            run_wrap              - restart at k=0 (pos=0)
//            cfg_max_run, cfg_wrap - configuration sampled on load
//            k, wrap               - current run length, latched wrap flag
//            last_one              - pos == k-1
//            last_run              - k == max_run
//            run_zero              - k == 0
// Revision : 1.0 - initial release
// ============================================================================
module seq_run_cnt
    import seq_gen_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic             i_clk,
    input  wire logic             i_resetn,
    input  wire logic             load,
    input  wire logic             pos_inc,
    input  wire logic             run_next,
    input  wire logic             run_wrap,
    input  wire logic [CNT_W-1:0] cfg_max_run,
    input  wire logic             cfg_wrap,
    output logic      [CNT_W-1:0] k,
    output logic                  wrap,
    output logic                  last_one,
    output logic                  last_run,
    output logic                  run_zero
);

    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] max_run;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            k       <= '0;
            pos     <= '0;
            max_run <= '0;
            wrap    <= 1'b0;
        end else if (load) begin
            k       <= '0;
            pos     <= '0;
            max_run <= cfg_max_run;
            wrap    <= cfg_wrap;
        end else if (run_wrap) begin
            k       <= '0;
            pos     <= '0;
        end else if (run_next) begin
            // Only issued while k < max_run, so k cannot overflow.
            k       <= k + 1'b1;
            pos     <= '0;
        end else if (pos_inc) begin
            // pos stays below k here, so pos+1 <= k <= max_run.
            pos     <= pos + 1'b1;
        end
    end

    // Compare pos+1 against k one bit wider so k=0 never aliases to all-ones.
    assign last_one = ({1'b0, pos} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, k};
    assign last_run = (k == max_run);
    assign run_zero = (k == '0);

endmodule
`default_nettype wire

// File: rtl/seq_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_ctrl
// Purpose  : Emits the run-length pattern 0 | 1,0 | 1,1,0 | ... (k ones then
//            a zero, for k = 0..max_run) on a valid/ready stream under
//            start/stop control, with optional wrap back to k=0.
// Ports    : i_clk, i_resetn  - clock, async active-low reset
//            i_start, i_stop  - start pulse (IDLE only), abort request
//            i_cfg_max_run    - last run length, sampled on start
//            i_cfg_wrap       - restart at k=0 after max_run, sampled on start
//            stream           - symbol stream (seq / seq_vld / seq_rdy)
//            o_busy           - high while not IDLE
//            o_done           - 1-cycle pulse after normal completion
//            o_run_len        - k being emitted, 0 in IDLE
//            o_sym_cnt        - accepted symbols since start (optional)
// Options  : SEQ_GEN_CTRL_SYM_CNT_EN adds o_sym_cnt[31:0], cleared on start,
//            saturating at all-ones, held in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen_ctrl
    import seq_gen_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic             i_clk,
    input  wire logic             i_resetn,
    input  wire logic             i_start,
    input  wire logic             i_stop,
    input  wire logic [CNT_W-1:0] i_cfg_max_run,
    input  wire logic             i_cfg_wrap,
    seq_gen_ctrl_if.master        stream,
    output logic                  o_busy,
    output logic                  o_done,
`ifdef SEQ_GEN_CTRL_SYM_CNT_EN
    output logic      [31:0]      o_sym_cnt,
`endif
    output logic      [CNT_W-1:0] o_run_len
);

    state_t           state;
    state_t           state_nxt;
    logic             drain_sym;
    logic             done_set;
    logic             seq;
    logic             seq_vld;
    logic             xfer;
    logic             load;
    logic             pos_inc;
    logic             run_next;
    logic             run_wrap;
    logic [CNT_W-1:0] k;
    logic             wrap;
    logic             last_one;
    logic             last_run;
    logic             run_zero;

    seq_run_cnt #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .load        (load),
        .pos_inc     (pos_inc),
        .run_next    (run_next),
        .run_wrap    (run_wrap),
        .cfg_max_run (i_cfg_max_run),
        .cfg_wrap    (i_cfg_wrap),
        .k           (k),
        .wrap        (wrap),
        .last_one    (last_one),
        .last_run    (last_run),
        .run_zero    (run_zero)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state     <= ST_IDLE;
            drain_sym <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= done_set;
            // Remember the stalled symbol so DRAIN keeps presenting it.
            if (state_nxt == ST_DRAIN && state != ST_DRAIN)
                drain_sym <= seq;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pos_inc   = 1'b0;
        run_next  = 1'b0;
        run_wrap  = 1'b0;
        done_set  = 1'b0;
        seq       = 1'b0;
        seq_vld   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    load      = 1'b1;
                    // k is cleared on load, so every run starts with a zero.
                    state_nxt = ST_ZERO;
                end
            end
            ST_ONES: begin
                seq     = 1'b1;
                seq_vld = 1'b1;
                if (i_stop) begin
                    state_nxt = stream.seq_rdy ? ST_IDLE : ST_DRAIN;
                end else if (stream.seq_rdy) begin
                    pos_inc = 1'b1;
                    if (last_one || run_zero)
                        state_nxt = ST_ZERO;
                end
            end
            ST_ZERO: begin
                seq_vld = 1'b1;
                if (i_stop) begin
                    state_nxt = stream.seq_rdy ? ST_IDLE : ST_DRAIN;
                end else if (stream.seq_rdy) begin
                    if (last_run) begin
                        if (wrap) begin
                            run_wrap = 1'b1;
                        end else begin
                            done_set  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        run_next  = 1'b1;
                        state_nxt = ST_ONES;
                    end
                end
            end
            ST_DRAIN: begin
                seq     = drain_sym;
                seq_vld = 1'b1;
                if (stream.seq_rdy)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign xfer           = seq_vld & stream.seq_rdy;
    assign stream.seq     = seq;
    assign stream.seq_vld = seq_vld;
    assign o_busy         = (state != ST_IDLE);
    assign o_run_len      = (state == ST_IDLE) ? '0 : k;

`ifdef SEQ_GEN_CTRL_SYM_CNT_EN
    logic [31:0] sym_cnt;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            sym_cnt <= '0;
        else if (load)
            sym_cnt <= '0;
        else if (xfer && sym_cnt != 32'hFFFF_FFFF)
            sym_cnt <= sym_cnt + 32'd1;
    end

    assign o_sym_cnt = sym_cnt;
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen_ctrl
// Purpose  : Directed self-checking bench for seq_gen_ctrl with
//            hand-computed expected symbol streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] max_run;
    logic             wrap;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] run_len;
`ifdef SEQ_GEN_CTRL_SYM_CNT_EN
    logic [31:0]      sym_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    seq_gen_ctrl_if sif ();

    seq_gen_ctrl #(
        .CNT_W (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_start       (start),
        .i_stop        (stop),
        .i_cfg_max_run (max_run),
        .i_cfg_wrap    (wrap),
        .stream        (sif.master),
        .o_busy        (busy),
        .o_done        (done),
`ifdef SEQ_GEN_CTRL_SYM_CNT_EN
        .o_sym_cnt     (sym_cnt),
`endif
        .o_run_len     (run_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] mr, input logic wr);
        max_run = mr;
        wrap    = wr;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        logic [5:0]       exp_seq;
        logic [CNT_W-1:0] exp_len [6];
        logic [2:0]       pat;
        logic             held;
        logic             stall;
        int               idx;
        int               nsym;
        int               nones;
        int               maxlen;
        int               seen_done;

        resetn      = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        max_run     = '0;
        wrap        = 1'b0;
        sif.seq_rdy = 1'b0;
        step();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vld", sif.seq_vld, 0);
        check_eq("rst_seq", sif.seq, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_len", run_len, 0);
        resetn = 1'b1;
        step();

        // 1: max_run=2, wrap=0, always ready -> 0,1,0,1,1,0 back to back
        exp_seq = 6'b011010;   // bit i = symbol i
        exp_len = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
        sif.seq_rdy = 1'b1;
        start_run(8'd2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t1_vld%0d", i), sif.seq_vld, 1);
            check_eq($sformatf("t1_seq%0d", i), sif.seq, exp_seq[i]);
            check_eq($sformatf("t1_len%0d", i), run_len, exp_len[i]);
            check_eq($sformatf("t1_done%0d", i), done, 0);
            step();
        end
        check_eq("t1_done", done, 1);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_vld_end", sif.seq_vld, 0);
`ifdef SEQ_GEN_CTRL_SYM_CNT_EN
        check_eq("t1_sym_cnt", sym_cnt, 6);
`endif
        step();
        check_eq("t1_done_pulse", done, 0);

        // 2: same cfg, ready toggling 1,0,1,0...
        sif.seq_rdy = 1'b1;
        start_run(8'd2, 1'b0);
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            sif.seq_rdy = (cyc % 2 == 0);
            stall = 1'b0;
            held  = sif.seq;
            if (sif.seq_vld) begin
                if (sif.seq_rdy) begin
                    check_eq($sformatf("t2_seq%0d", idx), sif.seq, exp_seq[idx]);
                    idx++;
                end else begin
                    stall = 1'b1;
                end
            end
            step();
            if (stall) begin
                check_eq("t2_hold_vld", sif.seq_vld, 1);
                check_eq("t2_hold_seq", sif.seq, held);
            end
        end
        check_eq("t2_count", idx, 6);
        check_eq("t2_done", done, 1);
        sif.seq_rdy = 1'b1;
        step();

        // 3: max_run=1, wrap=1 -> 0,1,0 repeating, never done; then stop
        pat = 3'b010;
        start_run(8'd1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("t3_seq%0d", i), sif.seq, pat[i % 3]);
            check_eq($sformatf("t3_done%0d", i), done, 0);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("t3_busy_stop", busy, 0);
        check_eq("t3_vld_stop", sif.seq_vld, 0);
        check_eq("t3_done_stop", done, 0);
        step();
        check_eq("t3_done_after", done, 0);

        // 4: max_run=3, stall in ONES, stop -> DRAIN holds the 1
        start_run(8'd3, 1'b0);
        step();                       // k=0 zero accepted, now ONES k=1
        sif.seq_rdy = 1'b0;
        step();
        check_eq("t4_ones_seq", sif.seq, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("t4_drain_vld", sif.seq_vld, 1);
        check_eq("t4_drain_seq", sif.seq, 1);
        check_eq("t4_drain_busy", busy, 1);
        check_eq("t4_drain_len", run_len, 1);
        step();
        check_eq("t4_drain_seq2", sif.seq, 1);
        sif.seq_rdy = 1'b1;
        step();
        check_eq("t4_idle_busy", busy, 0);
        check_eq("t4_idle_vld", sif.seq_vld, 0);
        check_eq("t4_no_done", done, 0);
        step();
        check_eq("t4_no_done2", done, 0);

        // 5: max_run=0 -> single 0 then done; start while busy ignored
        start_run(8'd0, 1'b0);
        check_eq("t5_seq", sif.seq, 0);
        check_eq("t5_vld", sif.seq_vld, 1);
        sif.seq_rdy = 1'b0;
        max_run     = 8'd5;
        start       = 1'b1;
        step();
        start = 1'b0;
        check_eq("t5_busy_hold", busy, 1);
        check_eq("t5_seq_hold", sif.seq, 0);
        check_eq("t5_len_hold", run_len, 0);
        sif.seq_rdy = 1'b1;
        step();
        check_eq("t5_done", done, 1);
        check_eq("t5_busy_end", busy, 0);
        step();
        check_eq("t5_stay_idle", busy, 0);
        check_eq("t5_done_pulse", done, 0);

        // 6: asynchronous reset mid-run at k=2, then full 255 run
        start_run(8'd3, 1'b0);
        step();
        step();
        step();
        check_eq("t6_len_pre", run_len, 2);
        #2 resetn = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_vld", sif.seq_vld, 0);
        check_eq("t6_rst_seq", sif.seq, 0);
        check_eq("t6_rst_len", run_len, 0);
        step();
        resetn = 1'b1;
        step();
        start_run(8'd255, 1'b0);
        nsym = 0; nones = 0; maxlen = 0; seen_done = 0;
        for (int cyc = 0; cyc < 40000 && seen_done == 0; cyc++) begin
            if (sif.seq_vld) begin
                nsym++;
                if (sif.seq) nones++;
                if (int'(run_len) > maxlen) maxlen = int'(run_len);
            end
            step();
            if (done) seen_done = 1;
        end
        check_eq("t6_done_seen", seen_done, 1);
        check_eq("t6_symbols", nsym, 32896);   // sum_{k=0..255}(k+1)
        check_eq("t6_ones", nones, 32640);     // sum_{k=0..255} k
        check_eq("t6_max_len", maxlen, 255);
        check_eq("t6_busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
